fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Readout stage directly downstream of `fifo_top`. Whenever the transmitter is enabled and the FIFO is not empty, it pops one 63-bit word, appends an odd-parity bit, and serializes the result as a UART-style frame on a single output line. Parity is not stored in the FIFO, so it is computed here, at readout time.

## Interface
Parameters:
- `FIFO_WIDTH`, default 63: word width delivered by the FIFO.
- `CLKS_PER_BIT`, default 2: clk cycles per serial bit, legal values 1 to 255.

Ports:
- `clk`  input  1: master clock; all logic is on the rising edge.
- `reset_n`  input  1: digital reset, asynchronous and active-low.
- `fifo_data`  input  FIFO_WIDTH: FIFO head word. It is valid whenever `fifo_empty`=0.
- `fifo_empty`  input  1: FIFO empty flag.
- `read_n`  output  1: FIFO pop request, active low. It is registered, and is low for exactly one cycle per frame.
- `tx_enable`  input  1: permits new frames to start.
- `tx_out`  output  1: serial line. It idles high and is registered.
- `tx_busy`  output  1: high while a frame is in flight.
- `words_sent`  output  16: count of completed frames; wraps at 2^16.

## Operation
- Frame format is 66 bits, sent in this order:
  - start bit (0);
  - `fifo_data[0]` through `fifo_data[62]`, LSB first;
  - parity bit, equal to ~^word, so the 64 bits of data plus parity have odd parity;
  - stop bit (1).
- States:
  - IDLE: `tx_out`=1 and `tx_busy`=0. When `tx_enable`=1 and `fifo_empty`=0, the next edge latches `fifo_data` into a 64-bit shift register as {parity, word}, drives `read_n` low for that cycle only, and moves to START.
  - START: `tx_out`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shifts out 64 bits, each held for CLKS_PER_BIT cycles. A bit counter runs from 0 to 63, then moves to STOP.
  - STOP: `tx_out`=1 for CLKS_PER_BIT cycles. On the last cycle, `words_sent` increments and the state returns to IDLE.
- `tx_busy`=1 in START, DATA and STOP.
- The baud counter is sized to hold CLKS_PER_BIT-1 and reloads at each bit boundary. With CLKS_PER_BIT=1 there is one cycle per bit.
- The word is captured into the block's own register. Changes to `fifo_data` or `fifo_empty` after capture, including the pop itself, do not affect the frame in flight.
- `tx_enable` is sampled only in IDLE. Deasserting it mid-frame lets the current frame finish; no new frame starts.
- If `fifo_empty` is 1 in IDLE, the block never asserts `read_n`, even with `tx_enable`=1. No underflow read is possible.
- Reset (asynchronous, any time, including mid-frame):
  - `tx_out`=1, `read_n`=1, `tx_busy`=0, `words_sent`=0, state IDLE.
  - The shift register and counters are cleared.
  - A partial frame is abandoned; no pop is reissued.

## Timing
- Let E be the edge at which IDLE sees `tx_enable`=1 and `fifo_empty`=0.
- From E+1 to E+2, `read_n`=0; the FIFO pops on edge E+2. The start bit begins at E+1.
- Data bit k occupies cycles E+1+CLKS_PER_BIT·(1+k) onward, each for CLKS_PER_BIT cycles.
- Parity is bit k=63; the stop bit follows it.
- Frame length is 66·CLKS_PER_BIT cycles.
- `words_sent` updates at the edge that leaves STOP.
- At least one IDLE cycle separates consecutive frames, so the minimum frame period is 66·CLKS_PER_BIT+1 cycles.
- One `read_n` pulse per frame; `read_n` is never low on two consecutive cycles.

## Test plan
- Reset check: with `reset_n` low, `tx_out`=1, `read_n`=1, `tx_busy`=0 and `words_sent`=0. Release reset with `fifo_empty`=1 and `tx_enable`=1: outputs stay idle for 200 cycles, and `read_n` is never low.
- Single frame with CLKS_PER_BIT=2 and word 63'h0:
  - exactly one `read_n` low cycle;
  - 132-cycle frame: start 0, 63 zeros, parity 1, stop 1;
  - `words_sent`=1.
- Word 63'h1 followed by word 63'h3, FIFO preloaded:
  - first word has parity 0, second has parity 1;
  - data is LSB first;
  - frames are 133 cycles apart;
  - exactly two `read_n` pulses, then idle once `fifo_empty`=1;
  - `words_sent`=2.
- Drop `tx_enable` in the middle of the data bits:
  - the current frame completes intact;
  - no further `read_n` while the FIFO remains non-empty;
  - reasserting `tx_enable` resumes with the next word.
- Assert `reset_n` low in the middle of data bit 30:
  - `tx_out` goes to 1 immediately, without waiting for clk;
  - `words_sent`=0;
  - after release, the next frame carries the current FIFO head word, and there is no extra pop.
- CLKS_PER_BIT=1 with random words 63'h5A5A_5A5A_5A5A_5A5A and 63'h7FFF_FFFF_FFFF_FFFF: the deserialized data and parity match, and each frame is 66 cycles.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO readout handshake between fifo_top and fifo_uart_tx.
// master: the reader (pops with read_n); slave: the FIFO.
interface fifo_uart_tx_if #(
   parameter int FIFO_WIDTH = 63
);
   logic [FIFO_WIDTH-1:0] fifo_data;
   logic                  fifo_empty;
   logic                  read_n;

   modport master (
      input  fifo_data,
      input  fifo_empty,
      output read_n
   );

   modport slave (
      output fifo_data,
      output fifo_empty,
      input  read_n
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one FIFO word whenever enabled and data is present,
// appends an odd-parity bit and sends it as a UART-style frame:
// start(0), word LSB first, parity (~^word), stop(1).
module fifo_uart_tx #(
   parameter int FIFO_WIDTH   = 63,
   parameter int CLKS_PER_BIT = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   fifo_uart_tx_if.master        fifo,
   input  logic                  tx_enable,
   output logic                  tx_out,
   output logic                  tx_busy,
   output logic [15:0]           words_sent
);

   localparam int FRAME_BITS = FIFO_WIDTH + 1;
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam int BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t                  state,    state_nx;
   logic [BAUD_W-1:0]       baud_cnt, baud_nx;
   logic [BIT_W-1:0]        bit_cnt,  bit_nx;
   logic [FRAME_BITS-1:0]   shreg,    shreg_nx;
   logic                    tx_nx;
   logic                    read_n_q, read_n_nx;
   logic [15:0]             words_nx;
   logic                    baud_last;

   assign baud_last   = (baud_cnt == BAUD_LAST);
   assign tx_busy     = (state != ST_IDLE);
   assign fifo.read_n = read_n_q;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state plus next values of every registered output and counter;
   // tx_out is computed one cycle ahead so the line itself comes from a flop.
   always_comb begin
      state_nx  = state;
      baud_nx   = baud_cnt;
      bit_nx    = bit_cnt;
      shreg_nx  = shreg;
      tx_nx     = tx_out;
      read_n_nx = 1'b1;
      words_nx  = words_sent;
      case (state)
         ST_IDLE: begin
            tx_nx = 1'b1;
            if (tx_enable && !fifo.fifo_empty) begin
               shreg_nx  = {~^fifo.fifo_data, fifo.fifo_data};
               read_n_nx = 1'b0;
               baud_nx   = '0;
               bit_nx    = '0;
               tx_nx     = 1'b0;
               state_nx  = ST_START;
            end
         end
         ST_START: begin
            if (baud_last) begin
               baud_nx  = '0;
               tx_nx    = shreg[0];
               state_nx = ST_DATA;
            end else begin
               baud_nx = baud_cnt + 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_last) begin
               baud_nx = '0;
               if (bit_cnt == BIT_LAST) begin
                  tx_nx    = 1'b1;
                  state_nx = ST_STOP;
               end else begin
                  bit_nx   = bit_cnt + 1'b1;
                  shreg_nx = {1'b0, shreg[FRAME_BITS-1:1]};
                  tx_nx    = shreg[1];
               end
            end else begin
               baud_nx = baud_cnt + 1'b1;
            end
         end
         ST_STOP: begin
            tx_nx = 1'b1;
            if (baud_last) begin
               baud_nx  = '0;
               words_nx = words_sent + 16'd1;
               state_nx = ST_IDLE;
            end else begin
               baud_nx = baud_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Datapath registers: shift register, counters, serial line, pop strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         tx_out     <= 1'b1;
         read_n_q   <= 1'b1;
         words_sent <= '0;
      end else begin
         baud_cnt   <= baud_nx;
         bit_cnt    <= bit_nx;
         shreg      <= shreg_nx;
         tx_out     <= tx_nx;
         read_n_q   <= read_n_nx;
         words_sent <= words_nx;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (CLKS_PER_BIT 2 and 1) fed by
// bench-side FIFOs, checked every cycle against a frame-timeline model,
// plus literal expectations from a deserializer.
module tb_fifo_uart_tx;

   localparam int W    = 63;
   localparam int CPB0 = 2;
   localparam int CPB1 = 1;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   logic [W-1:0] fmem [2][32];
   logic [4:0]   frd  [2] = '{5'd0, 5'd0};
   logic [4:0]   fwr  [2] = '{5'd0, 5'd0};
   logic         en   [2] = '{1'b0, 1'b0};
   logic         pend [2] = '{1'b0, 1'b0};
   int           pulses [2] = '{0, 0};

   logic         tx_out_w [2];
   logic         busy_w   [2];
   logic         rn_w     [2];
   logic [15:0]  ws_w     [2];

   fifo_uart_tx_if #(.FIFO_WIDTH(W)) if0 ();
   fifo_uart_tx_if #(.FIFO_WIDTH(W)) if1 ();

   assign if0.fifo_data  = fmem[0][frd[0]];
   assign if0.fifo_empty = (frd[0] == fwr[0]);
   assign if1.fifo_data  = fmem[1][frd[1]];
   assign if1.fifo_empty = (frd[1] == fwr[1]);
   assign rn_w[0]        = if0.read_n;
   assign rn_w[1]        = if1.read_n;

   fifo_uart_tx #(.FIFO_WIDTH(W), .CLKS_PER_BIT(CPB0)) dut0 (
      .clk        (clk),
      .reset_n    (reset_n),
      .fifo       (if0),
      .tx_enable  (en[0]),
      .tx_out     (tx_out_w[0]),
      .tx_busy    (busy_w[0]),
      .words_sent (ws_w[0])
   );

   fifo_uart_tx #(.FIFO_WIDTH(W), .CLKS_PER_BIT(CPB1)) dut1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .fifo       (if1),
      .tx_enable  (en[1]),
      .tx_out     (tx_out_w[1]),
      .tx_busy    (busy_w[1]),
      .words_sent (ws_w[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic int cpb_of(input int i);
      return (i == 0) ? CPB0 : CPB1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Bench FIFO: a low read_n seen during a cycle pops at the following edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         pend[i] <= !rn_w[i];
         if (!rn_w[i]) pulses[i] <= pulses[i] + 1;
      end
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++)
         if (pend[i]) frd[i] <= frd[i] + 5'd1;
   end

   task automatic push(input int i, input logic [W-1:0] w);
      fmem[i][fwr[i]] = w;
      fwr[i] = fwr[i] + 5'd1;
   endtask

   function automatic int fifo_count(input int i);
      logic [4:0] d;
      d = fwr[i] - frd[i];
      return int'(d);
   endfunction

   // Model: a frame is a 66-entry bit vector played out over 66*CPB cycles
   // starting the cycle after the launch edge; one idle cycle follows.
   logic        m_act   [2];
   int          m_t     [2];
   logic [65:0] m_frame [2];
   logic [15:0] m_words [2];

   always @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            m_act[i]   <= 1'b0;
            m_t[i]     <= 0;
            m_words[i] <= 16'd0;
         end else if (m_act[i]) begin
            if (m_t[i] == 66 * cpb_of(i) - 1) begin
               m_act[i]   <= 1'b0;
               m_words[i] <= m_words[i] + 16'd1;
            end else begin
               m_t[i] <= m_t[i] + 1;
            end
         end else if (en[i] && (fifo_count(i) != 0)) begin
            m_act[i]   <= 1'b1;
            m_t[i]     <= 0;
            m_frame[i] <= {1'b1, ~^fmem[i][frd[i]], fmem[i][frd[i]], 1'b0};
         end
      end
   end

   function automatic logic exp_tx(input int i);
      if (!m_act[i]) return 1'b1;
      return m_frame[i][7'(m_t[i] / cpb_of(i))];
   endfunction

   // Cycle-by-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("tx_out%0d@%0d", i, cyc), 64'(tx_out_w[i]), 64'(exp_tx(i)));
         check($sformatf("read_n%0d@%0d", i, cyc), 64'(rn_w[i]), 64'(!(m_act[i] && m_t[i] == 0)));
         check($sformatf("tx_busy%0d@%0d", i, cyc), 64'(busy_w[i]), 64'(m_act[i]));
         check($sformatf("words_sent%0d@%0d", i, cyc), 64'(ws_w[i]), 64'(m_words[i]));
      end
   end

   // Deserializer: waits (bounded) for a start bit and samples each bit.
   task automatic capture(input int i, output logic [W-1:0] word, output logic par,
                          output logic stp, output int t0);
      int  c;
      bit  seen;
      c = cpb_of(i);
      word = '0; par = 1'b0; stp = 1'b0; t0 = 0; seen = 1'b0;
      for (int k = 0; k < 600 && !seen; k++) begin
         @(negedge clk);
         if (tx_out_w[i] == 1'b0) seen = 1'b1;
      end
      if (!seen) begin
         check("frame_start_timeout", 64'd0, 64'd1);
         return;
      end
      t0 = cyc;
      for (int n = 0; n <= 66 * c; n++) begin
         if (n > 0) @(negedge clk);
         if (n >= c && n < 64 * c && (n % c) == 0) word[6'(n / c - 1)] = tx_out_w[i];
         if (n == 64 * c) par = tx_out_w[i];
         if (n == 65 * c) stp = tx_out_w[i];
         if (n == 66 * c - 1) check("busy_last_cycle", 64'(busy_w[i]), 64'd1);
         if (n == 66 * c) check("busy_after_frame", 64'(busy_w[i]), 64'd0);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] w, w2;
      logic         p, p2, s, s2;
      int           t0, t1;
      bit           seen;

      // Reset state and idle with an empty FIFO.
      repeat (3) @(negedge clk);
      check("rst_tx_out", 64'(tx_out_w[0]), 64'd1);
      check("rst_read_n", 64'(rn_w[0]), 64'd1);
      check("rst_busy", 64'(busy_w[0]), 64'd0);
      check("rst_words", 64'(ws_w[0]), 64'd0);
      reset_n = 1'b1;
      en[0]   = 1'b1;
      settle(200);
      check("empty_no_pop", 64'(pulses[0]), 64'd0);
      check("empty_idle_tx", 64'(tx_out_w[0]), 64'd1);

      // Single all-zero word.
      push(0, 63'h0);
      capture(0, w, p, s, t0);
      check("zero_word", 64'(w), 64'd0);
      check("zero_parity", 64'(p), 64'd1);
      check("zero_stop", 64'(s), 64'd1);
      settle(10);
      check("zero_words_sent", 64'(ws_w[0]), 64'd1);
      check("zero_pulses", 64'(pulses[0]), 64'd1);

      // Preloaded 1 then 3, back to back.
      en[0] = 1'b0;
      push(0, 63'h1);
      push(0, 63'h3);
      en[0] = 1'b1;
      capture(0, w, p, s, t0);
      capture(0, w2, p2, s2, t1);
      check("w1_data", 64'(w), 64'd1);
      check("w1_parity", 64'(p), 64'd0);
      check("w3_data", 64'(w2), 64'd3);
      check("w3_parity", 64'(p2), 64'd1);
      check("w3_stop", 64'(s2), 64'd1);
      check("frame_period_cpb2", 64'(t1 - t0), 64'd133);
      settle(20);
      check("pair_pulses", 64'(pulses[0]), 64'd3);
      check("pair_words_sent", 64'(ws_w[0]), 64'd3);
      check("pair_fifo_drained", 64'(fifo_count(0)), 64'd0);

      // Drop tx_enable mid-data: frame completes, no further pop until re-enabled.
      push(0, 63'h155);
      push(0, 63'h2AA);
      fork
         capture(0, w, p, s, t0);
         begin
            repeat (40) @(negedge clk);
            en[0] = 1'b0;
         end
      join
      check("gated_frame_data", 64'(w), 64'h155);
      check("gated_frame_stop", 64'(s), 64'd1);
      settle(300);
      check("gated_pulses", 64'(pulses[0]), 64'd4);
      check("gated_words_sent", 64'(ws_w[0]), 64'd4);
      check("gated_fifo_left", 64'(fifo_count(0)), 64'd1);
      en[0] = 1'b1;
      capture(0, w, p, s, t0);
      check("resume_data", 64'(w), 64'h2AA);
      settle(10);
      check("resume_words_sent", 64'(ws_w[0]), 64'd5);
      check("resume_pulses", 64'(pulses[0]), 64'd5);

      // Asynchronous reset in the middle of data bit 30.
      en[0] = 1'b0;
      push(0, 63'h0F0F);
      push(0, 63'h1234);
      en[0] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (tx_out_w[0] == 1'b0) seen = 1'b1;
      end
      check("abort_frame_started", 64'(seen), 64'd1);
      repeat (63) @(negedge clk);
      check("bit30_before_reset", 64'(tx_out_w[0]), 64'd0);
      #1 reset_n = 1'b0;
      #1;
      check("async_rst_tx_out", 64'(tx_out_w[0]), 64'd1);
      check("async_rst_busy", 64'(busy_w[0]), 64'd0);
      check("async_rst_words", 64'(ws_w[0]), 64'd0);
      check("async_rst_read_n", 64'(rn_w[0]), 64'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      capture(0, w, p, s, t0);
      check("post_rst_data", 64'(w), 64'h1234);
      check("post_rst_parity", 64'(p), 64'd0);
      settle(10);
      check("post_rst_words_sent", 64'(ws_w[0]), 64'd1);
      check("post_rst_pulses", 64'(pulses[0]), 64'd7);
      check("post_rst_fifo_drained", 64'(fifo_count(0)), 64'd0);

      // One clock per bit on the second instance.
      push(1, 63'(64'h5A5A_5A5A_5A5A_5A5A));
      push(1, 63'(64'h7FFF_FFFF_FFFF_FFFF));
      en[1] = 1'b1;
      capture(1, w, p, s, t0);
      capture(1, w2, p2, s2, t1);
      check("cpb1_5a_data", 64'(w), 64'h5A5A_5A5A_5A5A_5A5A);
      check("cpb1_5a_parity", 64'(p), 64'd1);
      check("cpb1_7f_data", 64'(w2), 64'h7FFF_FFFF_FFFF_FFFF);
      check("cpb1_7f_parity", 64'(p2), 64'd0);
      check("cpb1_7f_stop", 64'(s2), 64'd1);
      check("frame_period_cpb1", 64'(t1 - t0), 64'd67);
      settle(10);
      check("cpb1_words_sent", 64'(ws_w[1]), 64'd2);
      check("cpb1_pulses", 64'(pulses[1]), 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
